// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
// Divisor changes take effect only at a period boundary; stop completes the current period.
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] pend_val;
  logic             pend_flag;
  logic             pos_q;
  logic             neg_q;
  logic             pos_nxt;
  logic             run_nxt;
  logic             boundary;
  logic             load_ok;

  function automatic logic [WIDTH-1:0] ceil_half(input logic [WIDTH-1:0] n);
    return (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
  endfunction

  always_comb begin
    boundary = running && (cnt == div_cur - ONE);
    load_ok  = div_load && (div_in >= TWO);
    cnt_inc  = cnt + ONE;
    cnt_nxt  = cnt_inc;
    run_nxt  = running;
    pos_nxt  = 1'b0;
    // Idle and period boundary share one decision: start/continue a fresh period or park at 0.
    if (!running || boundary) begin
      cnt_nxt = '0;
      run_nxt = en;
      pos_nxt = en;
    end else begin
      pos_nxt = cnt_inc < ceil_half(div_cur);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      running   <= 1'b0;
      pos_q     <= 1'b0;
      tick      <= 1'b0;
      div_cur   <= DIV_RST;
      div_err   <= 1'b0;
      pend_flag <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      running <= run_nxt;
      pos_q   <= pos_nxt;
      tick    <= running && (cnt == '0);
      if (div_load) div_err <= !load_ok;
      if (boundary) pend_flag <= 1'b0;
      if (boundary && pend_flag) div_cur <= pend_val;
      // A load coinciding with a boundary becomes pending for the following boundary.
      if (load_ok) begin
        if (running) begin
          pend_flag <= 1'b1;
        end else begin
          div_cur   <= div_in;
          pend_flag <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok && running) pend_val <= div_in;
  end

  // Half-cycle delayed copy of pos_q; ANDing it in trims the odd-divisor high phase by half a clk.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= pos_q;
  end

  assign clk_out = div_cur[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed stimulus pushes expected period records; a monitor
// measures clk_out in half-cycles between period starts (located via tick) and compares.
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic [W-1:0] div_cur;
  logic         div_err;

  typedef struct {
    int per_h;
    int high_h;
    int dcur;
    bit stop;
  } rec_t;

  rec_t exp_q[$];
  logic samp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   mon_start;
  bit   mon_run;

  clk_div_prog #(.WIDTH(W), .RESET_DIV(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .div_cur  (div_cur),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push(input int p, input int h, input int d, input bit s);
    rec_t r;
    r.per_h  = p;
    r.high_h = h;
    r.dcur   = d;
    r.stop   = s;
    exp_q.push_back(r);
  endtask

  task automatic report(input bit s, input int start, input int stop_idx);
    rec_t e;
    int   per;
    int   hi;
    per = -1;
    hi  = -1;
    if (start >= 0) begin
      per = stop_idx - start;
      hi  = 0;
      for (int i = start; i < stop_idx; i++) if (samp_q[i]) hi++;
    end
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got stop=%0d period=%0d high=%0d div_cur=%0d, expected no event",
               s, per, hi, div_cur);
    end else begin
      e = exp_q.pop_front();
      chk("event_is_stop", int'(s), int'(e.stop));
      chk("period_halves", per, e.per_h);
      chk("high_halves", hi, e.high_h);
      chk("event_div_cur", int'(div_cur), e.dcur);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Monitor: one clk_out sample per half-cycle; period start is two samples before the tick sample.
  initial begin
    mon_start = -1;
    mon_run   = 1'b0;
    forever begin
      @(posedge clk or negedge clk);
      #1;
      if (!rst) begin
        samp_q.delete();
        mon_start = -1;
        mon_run   = 1'b0;
      end else begin
        samp_q.push_back(clk_out);
        if (!running) chk("idle_clk_out", int'(clk_out), 0);
        if (clk) begin
          if (!running) chk("idle_tick", int'(tick), 0);
          if (running && tick) begin
            report(1'b0, mon_start, samp_q.size() - 3);
            mon_start = samp_q.size() - 3;
          end else if (!running && mon_run) begin
            report(1'b1, mon_start, samp_q.size() - 1);
            mon_start = -1;
          end
          mon_run = running;
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    step(3);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_div_err", int'(div_err), 0);
    chk("rst_div_cur", int'(div_cur), 9);
    rst = 1'b1;
    step(2);

    // N=9 from reset
    en = 1'b1;
    push(-1, -1, 9, 0);
    push(18, 9, 9, 0);
    step(1);
    step(13);

    // Load 4 mid-period: the running 9-period completes first
    div_in = 8'd4; div_load = 1'b1;
    push(18, 9, 4, 0);
    push(8, 4, 4, 0);
    step(1);
    div_load = 1'b0;
    chk("div_cur_pending_9", int'(div_cur), 9);
    step(9);

    // Load 3 then 2 in one period: only 2 is applied
    div_in = 8'd3; div_load = 1'b1;
    push(8, 4, 2, 0);
    push(4, 2, 2, 0);
    step(1);
    div_in = 8'd2;
    step(1);
    div_load = 1'b0;
    step(3);

    // Illegal load of 1
    div_in = 8'd1; div_load = 1'b1;
    push(4, 2, 2, 0);
    step(1);
    div_load = 1'b0;
    chk("err_set", int'(div_err), 1);
    chk("div_cur_after_illegal", int'(div_cur), 2);
    step(1);

    // Legal load of 5 clears the error
    div_in = 8'd5; div_load = 1'b1;
    push(4, 2, 5, 0);
    step(1);
    div_load = 1'b0;
    chk("err_clear", int'(div_err), 0);
    chk("div_cur_pending_2", int'(div_cur), 2);
    step(2);
    chk("div_cur_5", int'(div_cur), 5);

    // Load 8, then stop at cnt=2 of an 8-period
    div_in = 8'd8; div_load = 1'b1;
    push(10, 5, 8, 0);
    push(16, 8, 8, 0);
    step(1);
    div_load = 1'b0;
    step(13);
    en = 1'b0;
    push(16, 8, 8, 1);
    step(6);
    chk("stop_running", int'(running), 0);
    chk("stop_clk_out", int'(clk_out), 0);
    step(3);

    // Restart
    en = 1'b1;
    push(-1, -1, 8, 0);
    push(16, 8, 8, 0);
    step(1);
    chk("restart_running", int'(running), 1);
    chk("restart_clk_out", int'(clk_out), 1);
    step(9);

    // Asynchronous reset in the high phase
    chk("pre_rst_clk_out", int'(clk_out), 1);
    chk("pre_rst_tick", int'(tick), 1);
    rst = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_div_cur", int'(div_cur), 9);
    chk("arst_div_err", int'(div_err), 0);
    step(4);
    rst = 1'b1;
    push(-1, -1, 9, 0);
    push(18, 9, 9, 0);
    push(18, 9, 9, 0);
    step(1);
    chk("post_rst_running", int'(running), 1);
    step(21);

    chk("leftover_expect", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
